// File: rtl/iterative_divider32.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with start/done handshake.
// Optional macro DIV_FAST_PATH_EN: short-circuit |a| < |b| in PREP (quotient 0, remainder a).
module iterative_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             move_flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIXUP, FINISH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    count_q, count_d;
    logic             signed_q, signed_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             overflow_case;

    assign shifted       = {rem_q, dvd_q[WIDTH-1]};
    assign diff          = shifted - {1'b0, divisor_q};
    assign overflow_case = signed_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == {WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            dvd_q       <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            signed_q    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dvd_q       <= dvd_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            count_q     <= count_d;
            signed_q    <= signed_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        dvd_d       = dvd_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        count_d     = count_q;
        signed_d    = signed_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    signed_d  = is_signed;
                    dvd_d     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
                    divisor_d = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
                    neg_q_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r_d   = is_signed && a[WIDTH-1];
                    state_d   = PREP;
                end
            end
            // Special results are loaded unsigned with the sign flags cleared and
            // routed through FIXUP, so every result reaches the outputs the same way.
            PREP: begin
                if (divisor_q == '0) begin
                    dvd_d   = '1;
                    rem_d   = a_q;
                    neg_q_d = 1'b0;
                    neg_r_d = 1'b0;
                    state_d = FIXUP;
                end else if (overflow_case) begin
                    dvd_d   = {1'b1, {(WIDTH-1){1'b0}}};
                    rem_d   = '0;
                    neg_q_d = 1'b0;
                    neg_r_d = 1'b0;
                    state_d = FIXUP;
`ifdef DIV_FAST_PATH_EN
                end else if (dvd_q < divisor_q) begin
                    dvd_d   = '0;
                    rem_d   = a_q;
                    neg_q_d = 1'b0;
                    neg_r_d = 1'b0;
                    state_d = FIXUP;
`endif
                end else begin
                    rem_d   = '0;
                    count_d = '0;
                    state_d = DIVIDE;
                end
            end
            // Quotient bits shift into the dividend register as its bits shift out.
            DIVIDE: begin
                rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                dvd_d   = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quotient_d  = neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
                remainder_d = neg_r_q ? (~rem_q + 1'b1) : rem_q;
                state_d     = FINISH;
            end
            FINISH: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (move_flush) begin
            state_d     = IDLE;
            a_d         = '0;
            b_d         = '0;
            dvd_d       = '0;
            divisor_d   = '0;
            rem_d       = '0;
            count_d     = '0;
            signed_d    = 1'b0;
            neg_q_d     = 1'b0;
            neg_r_d     = 1'b0;
            quotient_d  = '0;
            remainder_d = '0;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_iterative_divider32.sv
// Directed self-checking bench for iterative_divider32: arithmetic, special cases, latency and handshake.
// Expected fast-path latency follows DIV_FAST_PATH_EN when the bench is built with the same define.
module tb_iterative_divider32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic        move_flush;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;

    int checks = 0;
    int passes = 0;

`ifdef DIV_FAST_PATH_EN
    localparam int FAST_LAT = 2;
`else
    localparam int FAST_LAT = 34;
`endif

    iterative_divider32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .move_flush (move_flush),
        .a          (a),
        .b          (b),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation, scrambles the operands after the accept edge and
    // returns the number of edges after acceptance until done is seen (999 on timeout).
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv, output int lat);
        @(negedge clk);
        a         = av;
        b         = bv;
        is_signed = sv;
        start     = 1'b1;
        @(posedge clk);
        #1;
        a         = ~av;
        b         = 32'h0000_0001;
        is_signed = ~sv;
        lat       = 999;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_start();
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        is_signed  = 1'b0;
        move_flush = 1'b0;
        a          = '0;
        b          = '0;
        #12;
        checks++;
        if ({done, quotient, remainder} !== 65'd0) $display("[TB] FAIL reset_outputs: got done=%b q=%h r=%h, want 0/0/0", done, quotient, remainder);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat;
        run_op(32'd100, 32'd7, 1'b0, lat);
        checks++;
        if (lat !== 34) $display("[TB] FAIL unsigned_latency: got %0d, want 34", lat);
        else passes++;
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2) $display("[TB] FAIL unsigned_100_7: got q=%h r=%h, want 0000000e/00000002", quotient, remainder);
        else passes++;
        release_start();
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL done_drop: got %b, want 0", done);
        else passes++;
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) $display("[TB] FAIL unsigned_max_by_1: got q=%h r=%h, want ffffffff/00000000", quotient, remainder);
        else passes++;
        release_start();
    endtask

    task automatic test_signed();
        int lat;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
        checks++;
        if (lat !== 34) $display("[TB] FAIL signed_latency: got %0d, want 34", lat);
        else passes++;
        checks++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) $display("[TB] FAIL signed_m7_2: got q=%h r=%h, want fffffffd/ffffffff", quotient, remainder);
        else passes++;
        release_start();
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
        checks++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) $display("[TB] FAIL signed_7_m2: got q=%h r=%h, want fffffffd/00000001", quotient, remainder);
        else passes++;
        release_start();
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, lat);
        checks++;
        if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) $display("[TB] FAIL signed_m100_7: got q=%h r=%h, want fffffff2/fffffffe", quotient, remainder);
        else passes++;
        release_start();
    endtask

    task automatic test_div_zero();
        int lat;
        for (int s = 0; s < 2; s++) begin
            run_op(32'h1234_5678, 32'd0, s[0], lat);
            checks++;
            if (lat !== 2) $display("[TB] FAIL divzero_latency_s%0d: got %0d, want 2", s, lat);
            else passes++;
            checks++;
            if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678) $display("[TB] FAIL divzero_s%0d: got q=%h r=%h, want ffffffff/12345678", s, quotient, remainder);
            else passes++;
            release_start();
        end
        run_op(32'hF000_0000, 32'd0, 1'b1, lat);
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'hF000_0000) $display("[TB] FAIL divzero_neg: got q=%h r=%h, want ffffffff/f0000000", quotient, remainder);
        else passes++;
        release_start();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        checks++;
        if (lat !== 2) $display("[TB] FAIL overflow_latency: got %0d, want 2", lat);
        else passes++;
        checks++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0) $display("[TB] FAIL overflow_signed: got q=%h r=%h, want 80000000/00000000", quotient, remainder);
        else passes++;
        release_start();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        checks++;
        if (lat !== FAST_LAT) $display("[TB] FAIL overflow_unsigned_latency: got %0d, want %0d", lat, FAST_LAT);
        else passes++;
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'h8000_0000) $display("[TB] FAIL overflow_unsigned: got q=%h r=%h, want 00000000/80000000", quotient, remainder);
        else passes++;
        release_start();
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        @(negedge clk);
        a         = 32'd1000;
        b         = 32'd3;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(posedge clk);
        #1;
        move_flush = 1'b1;
        @(posedge clk);
        #1;
        move_flush = 1'b0;
        checks++;
        if ({done, quotient, remainder} !== 65'd0) $display("[TB] FAIL flush_clear: got done=%b q=%h r=%h, want 0/0/0", done, quotient, remainder);
        else passes++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) $display("[TB] FAIL flush_no_done: got %0d done cycles, want 0", seen);
        else passes++;
        run_op(32'd9, 32'd3, 1'b0, lat);
        checks++;
        if (lat !== 34 || quotient !== 32'd3 || remainder !== 32'd0) $display("[TB] FAIL after_flush_9_3: got lat=%0d q=%h r=%h, want 34/00000003/00000000", lat, quotient, remainder);
        else passes++;
        release_start();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        run_op(32'd20, 32'd6, 1'b0, lat);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (!done || quotient !== 32'd3 || remainder !== 32'd2) bad++;
        end
        checks++;
        if (lat !== 34 || bad !== 0) $display("[TB] FAIL hold_start_finish: got lat=%0d bad_cycles=%0d q=%h r=%h, want 34/0/00000003/00000002", lat, bad, quotient, remainder);
        else passes++;
        release_start();
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL hold_release: got done=%b, want 0", done);
        else passes++;
        run_op(32'd45, 32'd7, 1'b0, lat);
        checks++;
        if (lat !== 34 || quotient !== 32'd6 || remainder !== 32'd3) $display("[TB] FAIL reissue_45_7: got lat=%0d q=%h r=%h, want 34/00000006/00000003", lat, quotient, remainder);
        else passes++;
        release_start();
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        a         = 32'd5000;
        b         = 32'd9;
        is_signed = 1'b0;
        start     = 1'b1;
        for (int i = 0; i < 8; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({done, quotient, remainder} !== 65'd0) $display("[TB] FAIL reset_mid: got done=%b q=%h r=%h, want 0/0/0", done, quotient, remainder);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd100, 32'd7, 1'b0, lat);
        checks++;
        if (lat !== 34 || quotient !== 32'd14 || remainder !== 32'd2) $display("[TB] FAIL after_reset_100_7: got lat=%0d q=%h r=%h, want 34/0000000e/00000002", lat, quotient, remainder);
        else passes++;
        release_start();
    endtask

    task automatic test_fast_path();
        int lat;
        run_op(32'd5, 32'd9, 1'b0, lat);
        checks++;
        if (lat !== FAST_LAT) $display("[TB] FAIL fast_latency: got %0d, want %0d", lat, FAST_LAT);
        else passes++;
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd5) $display("[TB] FAIL fast_5_9: got q=%h r=%h, want 00000000/00000005", quotient, remainder);
        else passes++;
        release_start();
        run_op(32'hFFFF_FFFB, 32'd9, 1'b1, lat);
        checks++;
        if (lat !== FAST_LAT || quotient !== 32'd0 || remainder !== 32'hFFFF_FFFB) $display("[TB] FAIL fast_m5_9: got lat=%0d q=%h r=%h, want %0d/00000000/fffffffb", lat, quotient, remainder, FAST_LAT);
        else passes++;
        release_start();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_fast_path();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
